// File: rtl/fu_pkg.sv
// -----------------------------------------------------------------------------
// fu_pkg
// Shared definitions for the functional unit (fu), its issue stage (fu_issue)
// and anything that drives them.
//   - Default datapath, opcode and register-address widths.
//   - Instruction word layout {op, rd, ra, rb} and its field offsets.
//   - Opcode values understood by fu.
//   - Bit positions of the Z/N/C/V flags in the {Z,N,C,V} flag vectors.
// -----------------------------------------------------------------------------
package fu_pkg;

   localparam int FU_DSIZE  = 16;
   localparam int FU_OPSIZE = 5;
   localparam int FU_AW     = 3;

   // Instruction word field offsets (LSB of each field) for the default widths
   localparam int INS_RB_LSB = 0;
   localparam int INS_RA_LSB = FU_AW;
   localparam int INS_RD_LSB = 2 * FU_AW;
   localparam int INS_OP_LSB = 3 * FU_AW;
   localparam int INS_W      = FU_OPSIZE + 3 * FU_AW;

   typedef struct packed {
      logic [FU_OPSIZE-1:0] op;
      logic [FU_AW-1:0]     rd;
      logic [FU_AW-1:0]     ra;
      logic [FU_AW-1:0]     rb;
   } ins_t;

   // Opcodes
   localparam logic [FU_OPSIZE-1:0] OP_NOP = 5'h00;
   localparam logic [FU_OPSIZE-1:0] OP_ADD = 5'h01;
   localparam logic [FU_OPSIZE-1:0] OP_SUB = 5'h02;
   localparam logic [FU_OPSIZE-1:0] OP_AND = 5'h03;
   localparam logic [FU_OPSIZE-1:0] OP_OR  = 5'h04;
   localparam logic [FU_OPSIZE-1:0] OP_XOR = 5'h05;

   // Flag bit indices within {Z,N,C,V}
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/fu_regfile.sv
// -----------------------------------------------------------------------------
// fu_regfile
// Register file for the fu issue stage: 2**AW registers of DSIZE bits,
// two combinational read ports and two write ports. The writeback port has
// priority over the preload port when both target the same register.
// Asynchronous active-low reset clears every register.
//   clk, rst_n           clock, async active-low reset
//   ra_addr_i/ra_data_o  read port A
//   rb_addr_i/rb_data_o  read port B
//   wb_en_i/addr/data    writeback port (priority)
//   ld_en_i/addr/data    preload port
// -----------------------------------------------------------------------------
module fu_regfile
   import fu_pkg::*;
#(
   parameter int DSIZE = FU_DSIZE,
   parameter int AW    = FU_AW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    ra_addr_i,
   output logic [DSIZE-1:0] ra_data_o,
   input  logic [AW-1:0]    rb_addr_i,
   output logic [DSIZE-1:0] rb_data_o,
   input  logic             wb_en_i,
   input  logic [AW-1:0]    wb_addr_i,
   input  logic [DSIZE-1:0] wb_data_i,
   input  logic             ld_en_i,
   input  logic [AW-1:0]    ld_addr_i,
   input  logic [DSIZE-1:0] ld_data_i
);

   localparam int NREG = 1 << AW;

   logic [DSIZE-1:0] regs_q [NREG];
   logic [NREG-1:0]  wb_sel;
   logic [NREG-1:0]  ld_sel;

   // One-hot write decode per register
   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_sel
         assign wb_sel[gi] = wb_en_i && (wb_addr_i == AW'(gi));
         assign ld_sel[gi] = ld_en_i && (ld_addr_i == AW'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            // A result leaving the pipeline overrides a preload to the same register
            if (wb_sel[i]) begin
               regs_q[i] <= wb_data_i;
            end else if (ld_sel[i]) begin
               regs_q[i] <= ld_data_i;
            end
         end
      end
   end

   assign ra_data_o = regs_q[ra_addr_i];
   assign rb_data_o = regs_q[rb_addr_i];

endmodule

// File: rtl/fu_issue.sv
// -----------------------------------------------------------------------------
// fu_issue
// Issue/operand stage directly upstream of fu. Accepts {op, rd, ra, rb}
// instructions over valid/ready, reads both sources from a local register
// file, and drives registered op/data_a/data_b into fu. Two cycles after
// accept, fu's result is written to regs[rd] and its flags are latched.
// Read-after-write hazards against the two in-flight slots (ISS, EX) stall
// the input by dropping ins_ready and inserting a bubble.
//
// Build option: FU_BYPASS_EN
//   defined   - a source matching the EX slot's rd takes F_i directly;
//               only an ISS match stalls (one bubble for a dependent pair).
//   undefined - any ISS/EX match stalls until the result is in regs
//               (two bubbles for a dependent pair).
//
// Ports
//   clk, rst_n              clock, async active-low reset
//   ins_valid/ins_ready/ins instruction handshake, ins = {op, rd, ra, rb}
//   ld_en/ld_addr/ld_data   register preload
//   op_o, data_a_o, data_b_o  registered operands to fu
//   F_i, flags_i            fu result and {Z,N,C,V}
//   flags_o                 status register {Z,N,C,V}
//   busy_o                  an instruction is in ISS or EX
// -----------------------------------------------------------------------------
module fu_issue
   import fu_pkg::*;
#(
   parameter int DSIZE  = FU_DSIZE,
   parameter int OPSIZE = FU_OPSIZE,
   parameter int AW     = FU_AW
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ins_valid,
   output logic                   ins_ready,
   input  logic [OPSIZE+3*AW-1:0] ins,
   input  logic                   ld_en,
   input  logic [AW-1:0]          ld_addr,
   input  logic [DSIZE-1:0]       ld_data,
   output logic [OPSIZE-1:0]      op_o,
   output logic [DSIZE-1:0]       data_a_o,
   output logic [DSIZE-1:0]       data_b_o,
   input  logic [DSIZE-1:0]       F_i,
   input  logic [3:0]             flags_i,
   output logic [3:0]             flags_o,
   output logic                   busy_o
);

   // Instruction fields
   logic [OPSIZE-1:0] ins_op;
   logic [AW-1:0]     ins_rd;
   logic [1:0][AW-1:0] src;      // [0] = ra, [1] = rb

   assign {ins_op, ins_rd, src[0], src[1]} = ins;

   // Pipeline tracking: only real instructions carry a valid bit
   logic          iss_v_q, ex_v_q;
   logic [AW-1:0] iss_rd_q, ex_rd_q;

   // Operand registers toward fu
   logic [OPSIZE-1:0] op_q,     op_d;
   logic [DSIZE-1:0]  data_a_q, data_a_d;
   logic [DSIZE-1:0]  data_b_q, data_b_d;
   logic [3:0]        flags_q;

   // Register file read data and the operands finally selected
   logic [1:0][DSIZE-1:0] rf_rd;
   logic [1:0][DSIZE-1:0] opnd;

   logic [1:0] hit_iss;
   logic [1:0] hit_ex;
   logic       hazard;
   logic       accept;

   fu_regfile #(
      .DSIZE (DSIZE),
      .AW    (AW)
   ) u_rf (
      .clk       (clk),
      .rst_n     (rst_n),
      .ra_addr_i (src[0]),
      .ra_data_o (rf_rd[0]),
      .rb_addr_i (src[1]),
      .rb_data_o (rf_rd[1]),
      .wb_en_i   (ex_v_q),
      .wb_addr_i (ex_rd_q),
      .wb_data_i (F_i),
      .ld_en_i   (ld_en),
      .ld_addr_i (ld_addr),
      .ld_data_i (ld_data)
   );

   // Per-source comparison against the rd of each valid in-flight slot
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cmp
         assign hit_iss[gi] = iss_v_q && (src[gi] == iss_rd_q);
         assign hit_ex[gi]  = ex_v_q  && (src[gi] == ex_rd_q);
      end
   endgenerate

`ifdef FU_BYPASS_EN
   // The EX result is already on F_i, so it can be forwarded; the ISS result
   // does not exist yet (fu registers it at the next edge), so that stalls.
   // When both slots match, ISS is younger and the stall takes precedence.
   assign hazard = |hit_iss;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
         assign opnd[gi] = hit_ex[gi] ? F_i : rf_rd[gi];
      end
   endgenerate
`else
   assign hazard = (|hit_iss) | (|hit_ex);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
         assign opnd[gi] = rf_rd[gi];
      end
   endgenerate
`endif

   // Ready depends only on the instruction and in-flight state, never on valid
   assign ins_ready = !hazard;
   assign accept    = ins_valid && ins_ready;

   // A bubble drives all-zero operands into fu
   always_comb begin
      op_d     = '0;
      data_a_d = '0;
      data_b_d = '0;
      if (accept) begin
         op_d     = ins_op;
         data_a_d = opnd[0];
         data_b_d = opnd[1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         data_a_q <= '0;
         data_b_q <= '0;
         iss_v_q  <= 1'b0;
         iss_rd_q <= '0;
         ex_v_q   <= 1'b0;
         ex_rd_q  <= '0;
         flags_q  <= '0;
      end else begin
         op_q     <= op_d;
         data_a_q <= data_a_d;
         data_b_q <= data_b_d;
         iss_v_q  <= accept;
         iss_rd_q <= ins_rd;
         ex_v_q   <= iss_v_q;
         ex_rd_q  <= iss_rd_q;
         // Flags follow the writeback of a real instruction only
         if (ex_v_q) begin
            flags_q <= flags_i;
         end
      end
   end

   assign op_o     = op_q;
   assign data_a_o = data_a_q;
   assign data_b_o = data_b_q;
   assign flags_o  = flags_q;
   assign busy_o   = iss_v_q | ex_v_q;

endmodule
